ex_hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the RV32I EX stage.
- Generates the two 2-bit forwarding selects for the EX operand muxes.
- Detects load-use hazards and stalls F/D while inserting an EX bubble.
- Flushes D/E on a taken branch or jump (PCSrc_E).
- Runs a counter-based FSM that holds the pipeline while a multi-cycle EX operation (MUL/DIV class) occupies EX, then pulses completion.

---
 rtl/ex_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_ex_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use stall, branch flush,
// and a counter FSM that holds the pipeline while a multi-cycle op sits in EX.
module ex_hazard_ctrl #(
   parameter int unsigned MC_LAT      = 4,
   parameter logic [2:0]  RESULT_LOAD = 3'b001
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs1_D,
   input  logic [4:0] rs2_D,
   input  logic [4:0] rs1_E,
   input  logic [4:0] rs2_E,
   input  logic [4:0] rd_E,
   input  logic [2:0] resultScr_E,
   input  logic [4:0] rd_M,
   input  logic       regWrite_M,
   input  logic [4:0] rd_W,
   input  logic       regWrite_W,
   input  logic       PCSrc_E,
   input  logic       mc_req_E,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       stall_F,
   output logic       stall_D,
   output logic       stall_E,
   output logic       flush_D,
   output logic       flush_E,
   output logic       bubble_M,
   output logic       mc_busy,
   output logic       mc_done
);

   // Counter preload: the request cycle plus BUSY cycles (cnt down to 0) span MC_LAT.
   localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       lu, mcs;

   // M stage result is newer than W, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                          input logic wm, input logic [4:0] rdw,
                                          input logic ww);
      if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
      else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
      else                                     return 2'b00;
   endfunction

   assign ForwardAE = fwd_sel(rs1_E, rd_M, regWrite_M, rd_W, regWrite_W);
   assign ForwardBE = fwd_sel(rs2_E, rd_M, regWrite_M, rd_W, regWrite_W);

   assign lu = (resultScr_E == RESULT_LOAD) && (rd_E != 5'd0) &&
               ((rd_E == rs1_D) || (rd_E == rs2_D));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mcs       = 1'b0;
      mc_busy   = 1'b0;
      mc_done   = 1'b0;
      case (state)
         IDLE: begin
            if (mc_req_E) begin
               mcs       = 1'b1;
               cnt_nxt   = CNT_INIT;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            mcs     = 1'b1;
            mc_busy = 1'b1;
            if (cnt == 4'd0) state_nxt = DONE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         DONE: begin
            // mc_req_E here is still the finishing op, so it must not restart.
            mc_done   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A held mc op owns EX: no flushes while it stalls, and a taken branch kills the load-use stall.
   assign stall_E  = mcs;
   assign bubble_M = mcs;
   assign stall_F  = mcs | (lu & ~PCSrc_E);
   assign stall_D  = mcs | (lu & ~PCSrc_E);
   assign flush_D  = PCSrc_E & ~mcs;
   assign flush_E  = (PCSrc_E | lu) & ~mcs;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: stimulus pushes expected outputs from a
// cycle-count reference model; a negedge monitor pops and compares.
module tb_ex_hazard_ctrl;

   localparam int MC_LAT = 4;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E;
      logic [2:0] rscr;
      logic [4:0] rd_M;
      logic       rw_M;
      logic [4:0] rd_W;
      logic       rw_W;
      logic       pcsrc;
      logic       mc;
   } stim_t;

   // {fa, fb, stall_F, stall_D, stall_E, flush_D, flush_E, bubble_M, mc_busy, mc_done}
   typedef logic [11:0] resp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic [2:0] resultScr_E;
   logic       regWrite_M, regWrite_W, PCSrc_E, mc_req_E;
   logic [1:0] ForwardAE, ForwardBE;
   logic       stall_F, stall_D, stall_E, flush_D, flush_E, bubble_M, mc_busy, mc_done;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    mc_t    = -1;   // cycles since the current mc op entered EX; -1 when none
   resp_t exp_q[$];
   int    cyc_q[$];

   always #5 clk = ~clk;

   ex_hazard_ctrl #(.MC_LAT(MC_LAT), .RESULT_LOAD(3'b001)) dut (
      .clk(clk), .rst(rst),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .resultScr_E(resultScr_E), .rd_M(rd_M), .regWrite_M(regWrite_M),
      .rd_W(rd_W), .regWrite_W(regWrite_W), .PCSrc_E(PCSrc_E), .mc_req_E(mc_req_E),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
      .flush_D(flush_D), .flush_E(flush_E), .bubble_M(bubble_M),
      .mc_busy(mc_busy), .mc_done(mc_done)
   );

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
      if (s.rw_M && s.rd_M != 0 && s.rd_M == rs) return 2'b10;
      if (s.rw_W && s.rd_W != 0 && s.rd_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic resp_t ref_model(input stim_t s, input int t);
      logic load_use, hold, busy, done, st_fd, fl_d, fl_e;
      int   tt;
      tt       = (t < 0 && s.mc) ? 0 : t;
      hold     = (tt >= 0) && (tt < MC_LAT);
      busy     = (tt >= 1) && (tt < MC_LAT);
      done     = (tt == MC_LAT);
      load_use = (s.rscr == 3'b001) && (s.rd_E != 0) &&
                 ((s.rd_E == s.rs1_D) || (s.rd_E == s.rs2_D));
      if (hold) begin
         st_fd = 1; fl_d = 0; fl_e = 0;
      end else if (s.pcsrc) begin
         st_fd = 0; fl_d = 1; fl_e = 1;
      end else begin
         st_fd = load_use; fl_d = 0; fl_e = load_use;
      end
      return {ref_fwd(s.rs1_E, s), ref_fwd(s.rs2_E, s), st_fd, st_fd, hold,
              fl_d, fl_e, hold, busy, done};
   endfunction

   function automatic int next_t(input stim_t s, input int t);
      int tt;
      if (s.rst) return -1;
      tt = (t < 0 && s.mc) ? 0 : t;
      if (tt >= 0 && tt < MC_LAT) return tt + 1;
      return -1;
   endfunction

   task automatic drive(input stim_t s);
      rst = s.rst; rs1_D = s.rs1_D; rs2_D = s.rs2_D; rs1_E = s.rs1_E; rs2_E = s.rs2_E;
      rd_E = s.rd_E; resultScr_E = s.rscr; rd_M = s.rd_M; regWrite_M = s.rw_M;
      rd_W = s.rd_W; regWrite_W = s.rw_W; PCSrc_E = s.pcsrc; mc_req_E = s.mc;
   endtask

   task automatic step(input stim_t s);
      @(posedge clk); #1;
      cyc++;
      drive(s);
      exp_q.push_back(ref_model(s, mc_t));
      cyc_q.push_back(cyc);
      mc_t = next_t(s, mc_t);
   endtask

   always @(negedge clk) begin
      resp_t e, a;
      int    c;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         c = cyc_q.pop_front();
         a = {ForwardAE, ForwardBE, stall_F, stall_D, stall_E, flush_D, flush_E,
              bubble_M, mc_busy, mc_done};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL cycle%0d outputs: got %b want %b (fa fb sF sD sE fD fE bM busy done)",
                     c, a, e);
         end
      end
   end

   function automatic stim_t quiet();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst   = ($urandom_range(0, 39) == 0);
      s.rs1_D = 5'($urandom_range(0, 7));
      s.rs2_D = 5'($urandom_range(0, 7));
      s.rs1_E = 5'($urandom_range(0, 7));
      s.rs2_E = 5'($urandom_range(0, 7));
      s.rd_E  = 5'($urandom_range(0, 7));
      s.rscr  = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
      s.rd_M  = 5'($urandom_range(0, 7));
      s.rw_M  = 1'($urandom_range(0, 1));
      s.rd_W  = 5'($urandom_range(0, 7));
      s.rw_W  = 1'($urandom_range(0, 1));
      s.pcsrc = ($urandom_range(0, 4) == 0);
      s.mc    = ($urandom_range(0, 5) == 0);
      return s;
   endfunction

   initial begin
      stim_t s;
      drive(quiet());
      rst = 1'b1;
      @(posedge clk); #1;      // initial reset edge, DUT state unknown before it
      mc_t = -1;

      s = quiet(); s.rst = 1; step(s);   // reset state
      // forwarding: M, then W, then x0
      s = quiet(); s.rd_M = 5; s.rw_M = 1; s.rd_W = 5; s.rw_W = 1; s.rs1_E = 5; s.rs2_E = 5;
      step(s);
      s.rw_M = 0; step(s);
      s.rw_M = 1; s.rd_M = 0; s.rd_W = 0; step(s);
      // load-use, then rd_E = 0
      s = quiet(); s.rscr = 3'b001; s.rd_E = 7; s.rs2_D = 7; step(s);
      s.rd_E = 0; step(s);
      // load-use plus taken branch
      s.rd_E = 7; s.pcsrc = 1; step(s);
      // mc op with mc_req held through DONE and beyond
      s = quiet(); s.mc = 1;
      for (int i = 0; i < 7; i++) step(s);
      // branch and load-use during BUSY
      s = quiet(); step(s);
      s.mc = 1; step(s);
      s.pcsrc = 1; s.rscr = 3'b001; s.rd_E = 3; s.rs1_D = 3;
      for (int i = 0; i < 4; i++) step(s);
      s = quiet(); step(s);
      // reset in BUSY cycle 2, then no request
      s = quiet(); s.mc = 1; step(s);
      s.mc = 0; step(s);
      s.rst = 1; step(s);
      s.rst = 0;
      for (int i = 0; i < 6; i++) step(s);

      for (int i = 0; i < 2000; i++) step(rand_stim());

      @(negedge clk); #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
